// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped MIPS timer peripheral.
// Provides the register offsets (word index taken from memaddr[4:2]) and
// the bit positions inside the CTRL and STATUS registers.
package timer_pkg;

  // Word offsets within the 32-byte register window
  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_PRESCALE = 3'd1;
  localparam logic [2:0] TMR_COUNT    = 3'd2;
  localparam logic [2:0] TMR_COMPARE  = 3'd3;
  localparam logic [2:0] TMR_STATUS   = 3'd4;

  // CTRL register bit positions
  localparam int EN         = 0;
  localparam int AUTORELOAD = 1;
  localparam int IRQEN      = 2;
  localparam int ONESHOT    = 3;

  // STATUS register bit positions
  localparam int MATCH = 0;
  localparam int OVF   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: emits a one-cycle tick every (prescale+1) enabled
// cycles. The internal count holds while disabled and is cleared by a
// write to the PRESCALE register.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   en       - count enable (CTRL.EN)
//   prescale - terminal count value
//   clear    - synchronous clear of the internal count
//   tick     - advance strobe for the main counter
module timer_prescaler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] prescale,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // A PRESCALE write restarts the division so the new ratio applies cleanly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (clear || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 32'd1;
    end
  end

endmodule

// File: rtl/mips_timer_responder.sv
// Timer peripheral on the responder side of the MIPS data-memory bus.
// Decodes a 32-byte window at BASE_ADDR, returns register contents
// combinationally and applies stores at the clock edge. Holds a prescaled
// 32-bit up-counter with compare match, sticky MATCH/OVF flags and a level
// interrupt.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   memaddr       - CPU byte address (bits [1:0] ignored)
//   memwrite      - CPU store strobe
//   memwritedata  - CPU store data
//   memreaddata   - register read data (0 when not selected)
//   sel           - address hits the register window
//   irq           - MATCH & IRQEN, from registered state only
module mips_timer_responder
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        sel,
  output logic        irq
);

  logic [3:0]  ctrl,     ctrl_next;
  logic [31:0] prescale, prescale_next;
  logic [31:0] count,    count_next;
  logic [31:0] compare,  compare_next;
  logic [1:0]  status,   status_next;
  logic [1:0]  hw_set;
  logic [2:0]  offset;
  logic        wr_en;
  logic        tick;
  logic        unused_addr_bits;

  assign sel              = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign offset           = memaddr[4:2];
  assign wr_en            = memwrite && sel;
  assign unused_addr_bits = ^memaddr[1:0];
  assign irq              = status[MATCH] && ctrl[IRQEN];

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ctrl[EN]),
    .prescale (prescale),
    .clear    (wr_en && (offset == TMR_PRESCALE)),
    .tick     (tick)
  );

  // Hardware counter update first, then CPU writes override it. Match is
  // judged on the pre-edge COUNT/COMPARE, and flag sets survive a same-edge
  // W1C because hw_set is OR-ed back in.
  always_comb begin
    ctrl_next     = ctrl;
    prescale_next = prescale;
    count_next    = count;
    compare_next  = compare;
    hw_set        = 2'b00;

    if (tick) begin
      if (count == compare) begin
        hw_set[MATCH] = 1'b1;
        count_next    = ctrl[AUTORELOAD] ? 32'd0 : count + 32'd1;
        if (ctrl[ONESHOT]) begin
          ctrl_next[EN] = 1'b0;
        end
      end else if (count == 32'hFFFF_FFFF) begin
        hw_set[OVF] = 1'b1;
        count_next  = 32'd0;
      end else begin
        count_next = count + 32'd1;
      end
    end

    status_next = status | hw_set;

    if (wr_en) begin
      case (offset)
        TMR_CTRL:     ctrl_next     = memwritedata[3:0];
        TMR_PRESCALE: prescale_next = memwritedata;
        TMR_COUNT:    count_next    = memwritedata;
        TMR_COMPARE:  compare_next  = memwritedata;
        TMR_STATUS:   status_next   = (status & ~memwritedata[1:0]) | hw_set;
        default:      ;
      endcase
    end
  end

  // Register file state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= '0;
      status   <= '0;
    end else begin
      ctrl     <= ctrl_next;
      prescale <= prescale_next;
      count    <= count_next;
      compare  <= compare_next;
      status   <= status_next;
    end
  end

  // Combinational read path so the single-cycle CPU sees data immediately
  always_comb begin
    memreaddata = 32'h0;
    if (sel) begin
      case (offset)
        TMR_CTRL:     memreaddata = {28'h0, ctrl};
        TMR_PRESCALE: memreaddata = prescale;
        TMR_COUNT:    memreaddata = count;
        TMR_COMPARE:  memreaddata = compare;
        TMR_STATUS:   memreaddata = {30'h0, status};
        default:      memreaddata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_timer_responder.sv
// Self-checking bench for mips_timer_responder. A stimulus process drives one
// bus operation per cycle and pushes the expected read response into a
// queue; a monitor on the falling edge pops and compares. Expected values
// come from a behavioural timer model kept here.
module tb_mips_timer_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] memaddr;
  logic        memwrite;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        sel;
  logic        irq;
  logic        rdReq;

  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic        irq;
    string       nm;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state
  logic [3:0]  mCtrl;
  logic [31:0] mPre, mPcnt, mCount, mCmp;
  logic [1:0]  mStat;

  mips_timer_responder #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .memaddr      (memaddr),
    .memwrite     (memwrite),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .sel          (sel),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic inWin(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] addrOf(input logic [2:0] o);
    return BASE | {27'h0, o, 2'b00};
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!inWin(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return {28'h0, mCtrl};
      3'd1:    return mPre;
      3'd2:    return mCount;
      3'd3:    return mCmp;
      3'd4:    return {30'h0, mStat};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mCtrl = 0; mPre = 0; mPcnt = 0; mCount = 0; mCmp = 0; mStat = 0;
  endtask

  // Advance the model by one clock edge using the bus values held at that edge
  task automatic modelStep();
    logic        enabled, tick, hit;
    logic [3:0]  nCtrl;
    logic [31:0] nCount, nPcnt, nCmp, nPre;
    logic [1:0]  raised;
    if (!reset_n) begin
      modelReset();
    end else begin
      enabled = mCtrl[0];
      tick    = enabled && (mPcnt == mPre);
      hit     = memwrite && inWin(memaddr);
      nCtrl = mCtrl; nCount = mCount; nCmp = mCmp; nPre = mPre;
      raised = 2'b00;
      nPcnt = tick ? 32'd0 : (enabled ? mPcnt + 1 : mPcnt);
      if (tick) begin
        if (mCount == mCmp) begin
          raised[0] = 1'b1;
          nCount = mCtrl[1] ? 32'd0 : mCount + 1;
          if (mCtrl[3]) nCtrl[0] = 1'b0;
        end else if (mCount == 32'hFFFF_FFFF) begin
          raised[1] = 1'b1;
          nCount = 32'd0;
        end else begin
          nCount = mCount + 1;
        end
      end
      if (hit) begin
        case (memaddr[4:2])
          3'd0: nCtrl = memwritedata[3:0];
          3'd1: begin nPre = memwritedata; nPcnt = 0; end
          3'd2: nCount = memwritedata;
          3'd3: nCmp = memwritedata;
          default: ;
        endcase
      end
      if (hit && memaddr[4:2] == 3'd4) mStat = (mStat & ~memwritedata[1:0]) | raised;
      else mStat = mStat | raised;
      mCtrl = nCtrl; mCount = nCount; mPcnt = nPcnt; mCmp = nCmp; mPre = nPre;
    end
  endtask

  // One bus cycle: step the model at the edge, then drive the new operation
  task automatic busCycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic r, input string nm,
                          input logic useConst = 1'b0, input logic [31:0] cData = 32'h0,
                          input logic cIrq = 1'b0);
    exp_t e;
    @(posedge clk);
    modelStep();
    #1;
    memaddr = a; memwrite = w; memwritedata = d; rdReq = r;
    if (r) begin
      e.data = useConst ? cData : modelRead(a);
      e.sel  = inWin(a);
      e.irq  = useConst ? cIrq : (mStat[0] && mCtrl[2]);
      e.nm   = nm;
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] d);
    busCycle(addrOf(o), 1'b1, d, 1'b1, "wr");
  endtask

  task automatic rd(input logic [2:0] o, input string nm);
    busCycle(addrOf(o), 1'b0, 32'h0, 1'b1, nm);
  endtask

  task automatic rdConst(input logic [31:0] a, input logic [31:0] v, input logic i, input string nm);
    busCycle(a, 1'b0, 32'h0, 1'b1, nm, 1'b1, v, i);
  endtask

  // Monitor: compare whenever a read is presented
  always @(negedge clk) begin
    exp_t e;
    if (rdReq) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL underflow: got read with addr %h, want queued expectation", memaddr);
      end else begin
        e = expQ.pop_front();
        if (memreaddata !== e.data || sel !== e.sel || irq !== e.irq) begin
          bad++;
          $display("[TB] FAIL %s @%h: data got %h want %h, sel got %b want %b, irq got %b want %b",
                   e.nm, memaddr, memreaddata, e.data, sel, e.sel, irq, e.irq);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          r;
    memaddr = 0; memwrite = 0; memwritedata = 0; rdReq = 0;
    reset_n = 1'b0;
    modelReset();

    // Reset state
    repeat (2) busCycle(32'h0, 1'b0, 32'h0, 1'b0, "idle");
    @(posedge clk); modelStep(); #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) rdConst(addrOf(3'(i)), 32'h0, 1'b0, "reset_reg");
    rdConst(BASE + 32'h14, 32'h0, 1'b0, "reset_0x14");
    rdConst(32'h0000_0008, 32'h0, 1'b0, "outside_window");

    // Autoreload with interrupt, then W1C clears irq
    applyStimulus(3'd1, 0);
    applyStimulus(3'd3, 5);
    applyStimulus(3'd0, 32'h7);
    for (int i = 0; i < 10; i++) rd(3'd2, "autoreload_count");
    applyStimulus(3'd4, 1);
    for (int i = 0; i < 3; i++) rd(3'd4, "w1c_status");

    // Prescaled one-shot
    applyStimulus(3'd0, 0);
    applyStimulus(3'd4, 3);
    applyStimulus(3'd1, 3);
    applyStimulus(3'd3, 2);
    applyStimulus(3'd2, 0);
    applyStimulus(3'd0, 32'h9);
    for (int i = 0; i < 18; i++) rd(3'd2, "oneshot_count");
    rdConst(addrOf(3'd2), 32'd3, 1'b0, "oneshot_hold");
    rdConst(addrOf(3'd0), 32'h8, 1'b0, "oneshot_en_clear");
    rdConst(addrOf(3'd4), 32'h1, 1'b0, "oneshot_match");

    // Overflow then match at zero
    applyStimulus(3'd0, 0);
    applyStimulus(3'd4, 3);
    applyStimulus(3'd1, 0);
    applyStimulus(3'd3, 0);
    applyStimulus(3'd2, 32'hFFFF_FFFE);
    applyStimulus(3'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(3'd2, "ovf_count");
      rd(3'd4, "ovf_status");
    end

    // COUNT write collides with tick, W1C collides with match
    applyStimulus(3'd0, 0);
    applyStimulus(3'd3, 103);
    applyStimulus(3'd4, 3);
    applyStimulus(3'd0, 32'h1);
    applyStimulus(3'd2, 100);
    rdConst(addrOf(3'd2), 32'd100, 1'b0, "count_write_wins");
    rd(3'd2, "collide_count");
    rd(3'd2, "collide_count");
    busCycle(addrOf(3'd4), 1'b1, 32'h1, 1'b1, "w1c_on_match");
    rdConst(addrOf(3'd4), 32'h1, 1'b0, "set_beats_w1c");

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      a = addrOf(3'($urandom_range(0, 7))) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 3));
        2:       d = 32'($urandom_range(0, 30));
        default: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      endcase
      if (a[4:2] == 3'd1) d = 32'($urandom_range(0, 3));
      if (r < 5)      busCycle(a, 1'b0, 32'h0, 1'b1, "rand_rd");
      else if (r < 8) busCycle(a, 1'b1, d, 1'b1, "rand_wr");
      else if (r == 8) busCycle(BASE ^ (32'h1 << $urandom_range(5, 31)), 1'b1, d, 1'b1, "rand_miss");
      else            busCycle(32'h0, 1'b0, 32'h0, 1'b0, "idle");
    end

    // Asynchronous reset mid-count with irq active
    applyStimulus(3'd0, 0);
    applyStimulus(3'd1, 0);
    applyStimulus(3'd3, 2);
    applyStimulus(3'd2, 0);
    applyStimulus(3'd0, 32'h5);
    for (int i = 0; i < 5; i++) rd(3'd2, "pre_reset");
    @(posedge clk); modelStep();
    #1;
    memaddr = addrOf(3'd2); memwrite = 1'b0; rdReq = 1'b0;
    #2 reset_n = 1'b0;
    modelReset();
    #1;
    rdConst(addrOf(3'd2), 32'h0, 1'b0, "reset_count");
    rdConst(addrOf(3'd0), 32'h0, 1'b0, "reset_ctrl");
    @(posedge clk); modelStep(); #1 reset_n = 1'b1; rdReq = 1'b0;
    for (int i = 0; i < 4; i++) rdConst(addrOf(3'd2), 32'h0, 1'b0, "post_reset_hold");

    busCycle(32'h0, 1'b0, 32'h0, 1'b0, "idle");
    @(posedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drain: got %0d pending, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
